// File: rtl/arith_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : arith_result_fifo
// Brief    : Result FIFO behind the 8-bit arithmetic unit. Each entry holds
//            {op, f, flags}. Entries are handed to the consumer over a
//            valid/ready handshake. Sticky carry and overflow status are kept
//            alongside the FIFO.
// Options  : ARITH_FIFO_OVF_COUNT_EN - when defined, enables a saturating
//            8-bit count of accepted entries with V=1 on ovf_count.
//            When undefined, ovf_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module arith_result_fifo #(
  parameter int DEPTH = 4,  // entries, power of 2, >= 2
  parameter int AW    = 2   // log2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  // producer side
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [7:0]    in_f,
  input  logic [5:0]    in_flags,   // {C,V,Z,eq,gr,ls}
  // consumer side
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_op,
  output logic [7:0]    out_f,
  output logic [5:0]    out_flags,
  // status
  output logic [AW:0]   count,
  input  logic          clr_sticky,
  output logic          sticky_c,
  output logic          sticky_v,
  output logic [7:0]    ovf_count
);

  localparam int          EW       = 16;                 // entry width
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam int          C_BIT    = 5;
  localparam int          V_BIT    = 4;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [EW-1:0] mem_q    [DEPTH];
  logic [EW-1:0] mem_d    [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          sticky_c_q, sticky_c_d;
  logic          sticky_v_q, sticky_v_d;

  logic          full;
  logic          empty;
  logic          do_wr;
  logic          do_rd;
  logic          wr_c;
  logic          wr_v;
  logic [EW-1:0] head;

  // Full/empty come from the occupancy count, so pointers need no extra bit.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A full FIFO never accepts, even if the head is leaving this cycle.
  assign do_wr = in_valid && !full;
  assign do_rd = out_ready && !empty;

  assign wr_c  = do_wr && in_flags[C_BIT];
  assign wr_v  = do_wr && in_flags[V_BIT];

  // Head is a plain read of registered storage; no write-to-read bypass.
  assign head  = mem_q[rd_ptr_q];

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_op    = head[15:14];
  assign out_f     = head[13:6];
  assign out_flags = head[5:0];
  assign count     = count_q;
  assign sticky_c  = sticky_c_q;
  assign sticky_v  = sticky_v_q;

  // --------------------------------------------------------------------------
  // Next-state: storage, pointers and occupancy
  // --------------------------------------------------------------------------
  // Compute next storage, pointer and count values from the handshakes.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_wr) begin
      mem_d[wr_ptr_q] = {in_op, in_f, in_flags};
      wr_ptr_d        = wr_ptr_q + AW'(1);   // wraps modulo DEPTH
    end

    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state: sticky status
  // --------------------------------------------------------------------------
  // Clear first, then let an accepted write set; a setting write beats clear.
  always_comb begin
    sticky_c_d = clr_sticky ? 1'b0 : sticky_c_q;
    sticky_v_d = clr_sticky ? 1'b0 : sticky_v_q;
    if (wr_c) begin
      sticky_c_d = 1'b1;
    end
    if (wr_v) begin
      sticky_v_d = 1'b1;
    end
  end

  // Register FIFO and sticky state; reset discards every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sticky_c_q <= 1'b0;
      sticky_v_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sticky_c_q <= sticky_c_d;
      sticky_v_q <= sticky_v_d;
    end
  end

  // --------------------------------------------------------------------------
  // Overflow event counter
  // --------------------------------------------------------------------------
`ifdef ARITH_FIFO_OVF_COUNT_EN
  logic [7:0] ovf_count_q, ovf_count_d;

  // Saturating count of accepted V=1 writes; a write alongside clear restarts at 1.
  always_comb begin
    ovf_count_d = clr_sticky ? 8'd0 : ovf_count_q;
    if (wr_v) begin
      if (clr_sticky) begin
        ovf_count_d = 8'd1;
      end else if (ovf_count_q != 8'hFF) begin
        ovf_count_d = ovf_count_q + 8'd1;
      end
    end
  end

  // Register the overflow counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count_q <= 8'd0;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

  assign ovf_count = ovf_count_q;
`else
  assign ovf_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arith_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_result_fifo
// Brief    : Scoreboard bench for arith_result_fifo. Directed stimulus pushes
//            hand-computed entries into an expected queue; a negedge monitor
//            pops and compares whenever the DUT hands an entry over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arith_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [7:0] in_f;
  logic [5:0] in_flags;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_op;
  logic [7:0] out_f;
  logic [5:0] out_flags;
  logic [2:0] count;
  logic       clr_sticky;
  logic       sticky_c;
  logic       sticky_v;
  logic [7:0] ovf_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];

`ifdef ARITH_FIFO_OVF_COUNT_EN
  localparam int OVF_AFTER_ONE = 1;
  localparam int OVF_SAT       = 255;
`else
  localparam int OVF_AFTER_ONE = 0;
  localparam int OVF_SAT       = 0;
`endif

  arith_result_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_f       (in_f),
    .in_flags   (in_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_f      (out_f),
    .out_flags  (out_flags),
    .count      (count),
    .clr_sticky (clr_sticky),
    .sticky_c   (sticky_c),
    .sticky_v   (sticky_v),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for one cycle; queue it as expected if it should be accepted.
  task automatic put(input logic [1:0] op, input logic [7:0] f, input logic [5:0] fl,
                     input bit accept);
    in_valid = 1'b1;
    in_op    = op;
    in_f     = f;
    in_flags = fl;
    if (accept) exp_q.push_back({op, f, fl});
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: compare every handed-over entry against the scoreboard.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got f=%0d expected no entry", out_f);
      end else begin
        e = exp_q.pop_front();
        chk("pop_entry", {16'd0, out_op, out_f, out_flags}, {16'd0, e});
      end
    end
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = '0;
    in_f       = '0;
    in_flags   = '0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_f",     32'(out_f),     32'd0);
    chk("rst_ovf",       32'(ovf_count), 32'd0);
    rst = 1'b0;
    tick();

    // 200+100 -> 44 C=1 gr=1 ; 100-200 -> 156 C=0 ls=1, consumer stalled
    put(2'b00, 8'd44,  6'b100010, 1'b1);
    put(2'b01, 8'd156, 6'b000001, 1'b1);
    chk("t2_count",    32'(count),     32'd2);
    chk("t2_sticky_c", 32'(sticky_c),  32'd1);
    chk("t2_sticky_v", 32'(sticky_v),  32'd0);
    chk("t2_head_f",   32'(out_f),     32'd44);
    chk("t2_valid",    32'(out_valid), 32'd1);
    out_ready = 1'b1;
    repeat (2) tick();
    chk("t2_drained",  32'(count),     32'd0);
    out_ready = 1'b0;

    // Fill to full, then offer a 5th entry while the head is being read
    for (int i = 1; i <= 4; i++) put(2'b10, 8'(i), 6'b000000, 1'b1);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    chk("t3_full_count", 32'(count),    32'd4);
    out_ready = 1'b1;
    put(2'b11, 8'd5, 6'b000000, 1'b0);
    chk("t3_no_wr_through", 32'(count), 32'd3);
    repeat (3) tick();
    chk("t3_drained", 32'(count), 32'd0);

    // Streaming with consumer always ready; exercises pointer wrap
    for (int i = 0; i < 10; i++) begin
      put(2'(i), 8'(i), 6'(i), 1'b1);
      chk("t4_count_le1", 32'(count <= 3'd1), 32'd1);
    end
    tick();
    chk("t4_drained", 32'(count), 32'd0);

    // Clear and setting write in the same cycle: set wins for V, C clears
    clr_sticky = 1'b1;
    put(2'b00, 8'd200, 6'b010000, 1'b1);
    clr_sticky = 1'b0;
    chk("t5_sticky_v_set", 32'(sticky_v),  32'd1);
    chk("t5_sticky_c_clr", 32'(sticky_c),  32'd0);
    chk("t5_ovf_one",      32'(ovf_count), 32'(OVF_AFTER_ONE));
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("t5_sticky_v_clr", 32'(sticky_v),  32'd0);
    chk("t5_ovf_clr",      32'(ovf_count), 32'd0);

    // 260 V=1 writes: counter saturates
    for (int i = 0; i < 260; i++) put(2'b01, 8'(i), 6'b010000, 1'b1);
    tick();
    chk("t6_ovf_sat",  32'(ovf_count), 32'(OVF_SAT));
    chk("t6_sticky_v", 32'(sticky_v),  32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("t6_ovf_clr",  32'(ovf_count), 32'd0);

    // Asynchronous reset mid-run drops held entries and clears status
    out_ready = 1'b0;
    put(2'b00, 8'd1, 6'b110000, 1'b1);
    put(2'b00, 8'd2, 6'b000000, 1'b1);
    chk("t1_pre_count", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t1_in_ready",  32'(in_ready),  32'd1);
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_count",     32'(count),     32'd0);
    chk("t1_out_f",     32'(out_f),     32'd0);
    chk("t1_sticky_c",  32'(sticky_c),  32'd0);
    chk("t1_sticky_v",  32'(sticky_v),  32'd0);
    chk("t1_ovf",       32'(ovf_count), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("t1_post_count", 32'(count), 32'd0);
    chk("sb_all_popped", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
